// File: rtl/stage_3_tag_route.sv
// Stage-3 tag router: tags parity-clean host words toward the network and filters network words by tag toward the host.
// Optional build macro STAGE3_ERR_CNT_EN enables the saturating drop counters; otherwise they read 0.

module stage_3_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] head,
  output logic             full,
  output logic             overflow
);
  localparam int unsigned aw = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned cw = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [cw-1:0]    count;
  logic [cw-1:0]    count_nxt;
  logic             pop;
  logic             accept;

  assign valid    = (count != '0);
  assign head     = mem[rd_ptr];
  assign pop      = valid & ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign accept   = push & (~full | pop);
  assign overflow = push & full & ~pop;

  always_comb begin
    count_nxt = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + cw'(1);
      2'b01:   count_nxt = count - cw'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + aw'(1);
      end
      if (pop) rd_ptr <= rd_ptr + aw'(1);
      count <= count_nxt;
      full  <= (count_nxt == cw'(depth));
    end
  end
endmodule

module stage_3_tag_route #(
  parameter int unsigned data_size  = 32,
  parameter int unsigned tag_size   = 8,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned cnt_size   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   opcode_in,
  input  logic                         soft_error_in,
  input  logic [data_size-1:0]         tx_data_in,
  input  logic [data_size-1:0]         rx_data_in,
  input  logic [tag_size-1:0]          rx_tag_in,
  input  logic [tag_size-1:0]          node_tag,
  output logic                         net_valid,
  output logic [data_size+tag_size-1:0] net_data,
  input  logic                         net_ready,
  output logic                         host_valid,
  output logic [data_size-1:0]         host_data,
  input  logic                         host_ready,
  output logic                         tx_full,
  output logic                         rx_full,
  output logic [cnt_size-1:0]          parity_drop_cnt,
  output logic [cnt_size-1:0]          tag_miss_cnt,
  output logic [cnt_size-1:0]          overflow_cnt
);
  localparam logic [1:0] OP_RX    = 2'b01;
  localparam logic [1:0] OP_TX    = 2'b10;
  localparam logic [1:0] OP_RX_BC = 2'b11;

  logic tx_push;
  logic rx_push;
  logic tag_match;
  logic parity_drop;
  logic tag_miss;
  logic tx_ovf;
  logic rx_ovf;

  assign tag_match   = (rx_tag_in == node_tag) || (rx_tag_in == '1);
  assign tx_push     = (opcode_in == OP_TX) && !soft_error_in;
  assign parity_drop = (opcode_in == OP_TX) && soft_error_in;
  assign rx_push     = ((opcode_in == OP_RX) && tag_match) || (opcode_in == OP_RX_BC);
  assign tag_miss    = (opcode_in == OP_RX) && !tag_match;

  stage_3_fifo #(
    .width (data_size + tag_size),
    .depth (fifo_depth)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data ({tx_data_in, node_tag}),
    .ready     (net_ready),
    .valid     (net_valid),
    .head      (net_data),
    .full      (tx_full),
    .overflow  (tx_ovf)
  );

  stage_3_fifo #(
    .width (data_size),
    .depth (fifo_depth)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data_in),
    .ready     (host_ready),
    .valid     (host_valid),
    .head      (host_data),
    .full      (rx_full),
    .overflow  (rx_ovf)
  );

`ifdef STAGE3_ERR_CNT_EN
  // Only one opcode per cycle, so at most one drop event can fire per edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_drop_cnt <= '0;
      tag_miss_cnt    <= '0;
      overflow_cnt    <= '0;
    end else begin
      if (parity_drop && (parity_drop_cnt != '1)) parity_drop_cnt <= parity_drop_cnt + cnt_size'(1);
      if (tag_miss && (tag_miss_cnt != '1))       tag_miss_cnt    <= tag_miss_cnt + cnt_size'(1);
      if ((tx_ovf || rx_ovf) && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + cnt_size'(1);
    end
  end
`else
  logic unused_events;
  assign unused_events   = ^{parity_drop, tag_miss, tx_ovf, rx_ovf};
  assign parity_drop_cnt = '0;
  assign tag_miss_cnt    = '0;
  assign overflow_cnt    = '0;
`endif
endmodule

// File: tb/tb_stage_3_tag_route.sv
// Directed bench for stage_3_tag_route (fifo_depth=4, cnt_size=4); counter expectations follow STAGE3_ERR_CNT_EN.

module tb_stage_3_tag_route;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  opcode_in = 2'b00;
  logic        soft_error_in = 1'b0;
  logic [31:0] tx_data_in = '0;
  logic [31:0] rx_data_in = '0;
  logic [7:0]  rx_tag_in = '0;
  logic [7:0]  node_tag = 8'h5A;
  logic        net_valid;
  logic [39:0] net_data;
  logic        net_ready = 1'b0;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready = 1'b0;
  logic        tx_full;
  logic        rx_full;
  logic [3:0]  parity_drop_cnt;
  logic [3:0]  tag_miss_cnt;
  logic [3:0]  overflow_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stage_3_tag_route #(
    .data_size  (32),
    .tag_size   (8),
    .fifo_depth (4),
    .cnt_size   (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_in       (opcode_in),
    .soft_error_in   (soft_error_in),
    .tx_data_in      (tx_data_in),
    .rx_data_in      (rx_data_in),
    .rx_tag_in       (rx_tag_in),
    .node_tag        (node_tag),
    .net_valid       (net_valid),
    .net_data        (net_data),
    .net_ready       (net_ready),
    .host_valid      (host_valid),
    .host_data       (host_data),
    .host_ready      (host_ready),
    .tx_full         (tx_full),
    .rx_full         (rx_full),
    .parity_drop_cnt (parity_drop_cnt),
    .tag_miss_cnt    (tag_miss_cnt),
    .overflow_cnt    (overflow_cnt)
  );

  function automatic logic [3:0] cexp(input int n);
`ifdef STAGE3_ERR_CNT_EN
    return (n > 15) ? 4'hF : 4'(n);
`else
    return 4'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    opcode_in = 2'b00; soft_error_in = 1'b0; net_ready = 1'b0; host_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic do_tx(input logic [31:0] d, input logic se);
    opcode_in = 2'b10; tx_data_in = d; soft_error_in = se;
    tick();
    opcode_in = 2'b00; soft_error_in = 1'b0;
  endtask

  task automatic do_rx(input logic [1:0] op, input logic [7:0] tag, input logic [31:0] d);
    opcode_in = op; rx_tag_in = tag; rx_data_in = d;
    tick();
    opcode_in = 2'b00;
  endtask

  task automatic pop_host();
    host_ready = 1'b1;
    tick();
    host_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (net_valid !== 1'b0) begin bad++; $display("FAIL reset_net_valid got=%b exp=0", net_valid); end
    total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL reset_host_valid got=%b exp=0", host_valid); end
    total++; if ({tx_full, rx_full} !== 2'b00) begin bad++; $display("FAIL reset_full got=%b exp=00", {tx_full, rx_full}); end
    total++; if (net_data !== 40'h0) begin bad++; $display("FAIL reset_net_data got=%h exp=0", net_data); end
    total++; if (host_data !== 32'h0) begin bad++; $display("FAIL reset_host_data got=%h exp=0", host_data); end
    total++; if ({parity_drop_cnt, tag_miss_cnt, overflow_cnt} !== 12'h0) begin bad++;
      $display("FAIL reset_cnts got=%h exp=000", {parity_drop_cnt, tag_miss_cnt, overflow_cnt}); end
  endtask

  task automatic test_tx_basic();
    do_reset();
    do_tx(32'h1234_5678, 1'b0);
    total++; if (net_valid !== 1'b1) begin bad++; $display("FAIL tx_valid got=%b exp=1", net_valid); end
    total++; if (net_data !== 40'h12_3456_785A) begin bad++; $display("FAIL tx_data got=%h exp=123456785a", net_data); end
    net_ready = 1'b1;
    tick();
    net_ready = 1'b0;
    total++; if (net_valid !== 1'b0) begin bad++; $display("FAIL tx_pop_valid got=%b exp=0", net_valid); end
  endtask

  task automatic test_rx_route();
    do_reset();
    do_rx(2'b01, 8'h5A, 32'hCAFE_F00D);
    total++; if (host_valid !== 1'b1) begin bad++; $display("FAIL rx_match_valid got=%b exp=1", host_valid); end
    total++; if (host_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL rx_match_data got=%h exp=cafef00d", host_data); end
    pop_host();
    do_rx(2'b01, 8'h11, 32'h1111_1111);
    total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL rx_miss_valid got=%b exp=0", host_valid); end
    total++; if (tag_miss_cnt !== cexp(1)) begin bad++; $display("FAIL rx_miss_cnt got=%h exp=%h", tag_miss_cnt, cexp(1)); end
    do_rx(2'b01, 8'hFF, 32'hDEAD_BEEF);
    total++; if (host_data !== 32'hDEAD_BEEF || host_valid !== 1'b1) begin bad++;
      $display("FAIL rx_bcast_tag got=%b/%h exp=1/deadbeef", host_valid, host_data); end
    pop_host();
    do_rx(2'b11, 8'h11, 32'h0BAD_C0DE);
    total++; if (host_data !== 32'h0BAD_C0DE || host_valid !== 1'b1) begin bad++;
      $display("FAIL rx_bcast_op got=%b/%h exp=1/0badc0de", host_valid, host_data); end
    total++; if (tag_miss_cnt !== cexp(1)) begin bad++; $display("FAIL rx_bcast_cnt got=%h exp=%h", tag_miss_cnt, cexp(1)); end
    pop_host();
    soft_error_in = 1'b1;
    do_rx(2'b01, 8'h5A, 32'h5555_AAAA);
    soft_error_in = 1'b0;
    total++; if (host_data !== 32'h5555_AAAA || host_valid !== 1'b1) begin bad++;
      $display("FAIL rx_soft_ignored got=%b/%h exp=1/5555aaaa", host_valid, host_data); end
    total++; if (parity_drop_cnt !== 4'h0) begin bad++; $display("FAIL rx_soft_cnt got=%h exp=0", parity_drop_cnt); end
  endtask

  task automatic test_parity_drop();
    do_reset();
    do_tx(32'hFFFF_0000, 1'b1);
    total++; if (net_valid !== 1'b0) begin bad++; $display("FAIL parity_valid got=%b exp=0", net_valid); end
    total++; if (parity_drop_cnt !== cexp(1)) begin bad++; $display("FAIL parity_cnt got=%h exp=%h", parity_drop_cnt, cexp(1)); end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      w = 32'hA000_0000 + 32'(i);
      do_tx(w, 1'b0);
      if (i == 3) begin
        total++; if (tx_full !== 1'b0) begin bad++; $display("FAIL ovf_full3 got=%b exp=0", tx_full); end
      end
      if (i == 4) begin
        total++; if (tx_full !== 1'b1) begin bad++; $display("FAIL ovf_full4 got=%b exp=1", tx_full); end
      end
    end
    total++; if (overflow_cnt !== cexp(1)) begin bad++; $display("FAIL ovf_cnt got=%h exp=%h", overflow_cnt, cexp(1)); end
    for (int i = 1; i <= 4; i++) begin
      w = 32'hA000_0000 + 32'(i);
      total++; if (net_valid !== 1'b1 || net_data !== {w, 8'h5A}) begin bad++;
        $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, net_valid, net_data, {w, 8'h5A}); end
      net_ready = 1'b1;
      tick();
      net_ready = 1'b0;
    end
    total++; if (net_valid !== 1'b0 || tx_full !== 1'b0) begin bad++;
      $display("FAIL ovf_empty got=%b%b exp=00", net_valid, tx_full); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    do_reset();
    for (int i = 1; i <= 4; i++) do_tx(32'hB000_0000 + 32'(i), 1'b0);
    opcode_in = 2'b10; tx_data_in = 32'hB000_0005; net_ready = 1'b1;
    tick();
    opcode_in = 2'b00; net_ready = 1'b0;
    total++; if (tx_full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", tx_full); end
    total++; if (overflow_cnt !== 4'h0) begin bad++; $display("FAIL b2b_ovf got=%h exp=0", overflow_cnt); end
    for (int i = 2; i <= 5; i++) begin
      w = 32'hB000_0000 + 32'(i);
      total++; if (net_valid !== 1'b1 || net_data !== {w, 8'h5A}) begin bad++;
        $display("FAIL b2b_order%0d got=%b/%h exp=1/%h", i, net_valid, net_data, {w, 8'h5A}); end
      net_ready = 1'b1;
      tick();
      net_ready = 1'b0;
    end
    // Single entry: push and pop together keeps one word, the new one at head.
    do_tx(32'hC000_0001, 1'b0);
    opcode_in = 2'b10; tx_data_in = 32'hC000_0002; net_ready = 1'b1;
    tick();
    opcode_in = 2'b00; net_ready = 1'b0;
    total++; if (net_valid !== 1'b1 || net_data !== 40'hC0_0000_025A || tx_full !== 1'b0) begin bad++;
      $display("FAIL b2b_single got=%b/%h/%b exp=1/c00000025a/0", net_valid, net_data, tx_full); end
    for (int i = 1; i <= 5; i++) do_rx(2'b01, 8'h5A, 32'hD000_0000 + 32'(i));
    total++; if (rx_full !== 1'b1 || host_data !== 32'hD000_0001) begin bad++;
      $display("FAIL rx_full got=%b/%h exp=1/d0000001", rx_full, host_data); end
    total++; if (overflow_cnt !== cexp(1)) begin bad++; $display("FAIL rx_ovf_cnt got=%h exp=%h", overflow_cnt, cexp(1)); end
  endtask

  task automatic test_saturation();
    do_reset();
    opcode_in = 2'b01; rx_tag_in = 8'h11;
    for (int i = 0; i < 14; i++) tick();
    total++; if (tag_miss_cnt !== cexp(14)) begin bad++; $display("FAIL sat14 got=%h exp=%h", tag_miss_cnt, cexp(14)); end
    for (int i = 0; i < 6; i++) tick();
    opcode_in = 2'b00;
    total++; if (tag_miss_cnt !== cexp(20)) begin bad++; $display("FAIL sat20 got=%h exp=%h", tag_miss_cnt, cexp(20)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_tx(32'h0000_0001, 1'b1);
    for (int i = 1; i <= 5; i++) do_tx(32'hE000_0000 + 32'(i), 1'b0);
    do_rx(2'b01, 8'h5A, 32'h7777_7777);
    #2;
    reset = 1'b0;
    #1;
    total++; if ({net_valid, host_valid, tx_full, rx_full} !== 4'b0000) begin bad++;
      $display("FAIL midrst_flags got=%b exp=0000", {net_valid, host_valid, tx_full, rx_full}); end
    total++; if (net_data !== 40'h0 || host_data !== 32'h0) begin bad++;
      $display("FAIL midrst_data got=%h/%h exp=0/0", net_data, host_data); end
    total++; if ({parity_drop_cnt, tag_miss_cnt, overflow_cnt} !== 12'h0) begin bad++;
      $display("FAIL midrst_cnts got=%h exp=000", {parity_drop_cnt, tag_miss_cnt, overflow_cnt}); end
    #2;
    reset = 1'b1;
    tick();
    total++; if (net_valid !== 1'b0 || host_valid !== 1'b0) begin bad++;
      $display("FAIL midrst_after got=%b%b exp=00", net_valid, host_valid); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_route();
    test_parity_drop();
    test_overflow();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
